// File: rtl/function_profiler_pkg.sv
// ============================================================================
// function_profiler_pkg : shared state encoding and default sizes
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package function_profiler_pkg;

  localparam int c_addr_w = 32;
  localparam int c_depth  = 256;
  localparam int c_cnt_w  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/profiler_table.sv
// ============================================================================
// profiler_table : sorted function-start table, 1 sync write / 1 async read
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module profiler_table #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [ADDR_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [ADDR_W-1:0] o_rdata
);

  // Contents survive reset so software loads the table only once.
  logic [ADDR_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/function_profiler.sv
// ============================================================================
// function_profiler : binary-search PC to function lookup with hit counters
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module function_profiler
  import function_profiler_pkg::*;
#(
  parameter int ADDR_W = c_addr_w,
  parameter int DEPTH  = c_depth,
  parameter int CNT_W  = c_cnt_w,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tbl_we,
  input  logic [IDX_W-1:0]  tbl_waddr,
  input  logic [ADDR_W-1:0] tbl_wdata,
  input  logic [IDX_W:0]    tbl_count,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic [ADDR_W-1:0] pc,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_hit,
  output logic [IDX_W-1:0]  res_idx,
  output logic [ADDR_W-1:0] res_base,
  input  logic [IDX_W-1:0]  cnt_raddr,
  output logic [CNT_W-1:0]  cnt_rdata,
  output logic [CNT_W-1:0]  miss_cnt,
  input  logic              cnt_clr
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] w_rdata;
  logic [IDX_W-1:0]  r_lo;
  logic [IDX_W-1:0]  r_hi;
  logic [IDX_W-1:0]  r_ans;
  logic [IDX_W-1:0]  w_mid;
  logic [IDX_W-1:0]  w_last;
  logic              r_hit;
  logic              w_accept;
  logic              w_handshake;
  logic              w_le;
  logic              w_exit;
  logic [CNT_W-1:0]  r_cnt [DEPTH];
  logic [CNT_W-1:0]  r_miss;
  logic [CNT_W-1:0]  r_cnt_rdata;

  assign w_accept    = pc_valid && (r_state == IDLE);
  assign w_handshake = res_ready && (r_state == DONE);

  // A count of DEPTH or more means the whole table is valid.
  assign w_last = tbl_count[IDX_W] ? '1 : (tbl_count[IDX_W-1:0] - IDX_W'(1));
  assign w_mid  = r_lo + ((r_hi - r_lo) >> 1);
  assign w_le   = (w_rdata <= r_pc);
  // Exit on the probe that would cross lo/hi, so they never leave 0..DEPTH-1.
  assign w_exit = w_le ? (w_mid == r_hi) : (w_mid == r_lo);

  profiler_table #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_table (
    .clk     (clk),
    .i_we    (tbl_we && (r_state == IDLE)),
    .i_waddr (tbl_waddr),
    .i_wdata (tbl_wdata),
    .i_raddr (w_mid),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    pc_ready  = 1'b0;
    res_valid = 1'b0;
    res_hit   = 1'b0;
    res_idx   = '0;
    res_base  = '0;
    case (r_state)
      IDLE: begin
        pc_ready = 1'b1;
        if (pc_valid) begin
          w_next = (tbl_count == '0) ? DONE : SEARCH;
        end
      end
      SEARCH: begin
        if (w_exit) begin
          w_next = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        res_hit   = r_hit;
        res_idx   = r_ans;
        res_base  = r_base;
        if (res_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc   <= '0;
      r_lo   <= '0;
      r_hi   <= '0;
      r_ans  <= '0;
      r_hit  <= 1'b0;
      r_base <= '0;
    end else if (w_accept) begin
      r_pc   <= pc;
      r_lo   <= '0;
      r_hi   <= w_last;
      r_ans  <= '0;
      r_hit  <= 1'b0;
      r_base <= '0;
    end else if (r_state == SEARCH) begin
      if (w_le) begin
        r_ans  <= w_mid;
        r_hit  <= 1'b1;
        r_base <= w_rdata;
        r_lo   <= w_mid + IDX_W'(1);
      end else begin
        r_hi   <= w_mid - IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_cnt[i] <= '0;
      r_miss <= '0;
    end else if (cnt_clr) begin
      for (int i = 0; i < DEPTH; i++) r_cnt[i] <= '0;
      r_miss <= '0;
    end else if (w_handshake) begin
      if (r_hit) begin
        if (r_cnt[r_ans] != '1) r_cnt[r_ans] <= r_cnt[r_ans] + CNT_W'(1);
      end else if (r_miss != '1) begin
        r_miss <= r_miss + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt_rdata <= '0;
    end else begin
      r_cnt_rdata <= r_cnt[cnt_raddr];
    end
  end

  assign cnt_rdata = r_cnt_rdata;
  assign miss_cnt  = r_miss;

endmodule

`default_nettype wire

// File: doc/function_profiler.md
FUNCTION_PROFILER -- requirements
Module: function_profiler

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning PC and function-start-address width.
REQ-002 The block SHALL have parameter DEPTH, default 256, meaning table entries; it must be a power of two and at least 2. IDX_W = $clog2(DEPTH).
REQ-003 The block SHALL have parameter CNT_W, default 32, meaning hit/miss counter width.
REQ-004 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  is the asynchronous, active-low reset.
REQ-006 Ports tbl_we  input  1, tbl_waddr  input  IDX_W, tbl_wdata  input  ADDR_W SHALL form the table write port.
REQ-007 Port tbl_count  input  IDX_W+1 SHALL give the number of valid sorted entries (0..DEPTH); it is sampled at query accept.
REQ-008 Ports pc_valid  input  1, pc_ready  output  1, pc  input  ADDR_W SHALL form the query handshake.
REQ-009 Ports res_valid  output  1, res_ready  input  1, res_hit  output  1, res_idx  output  IDX_W, res_base  output  ADDR_W SHALL form the result handshake.
REQ-010 Ports cnt_raddr  input  IDX_W, cnt_rdata  output  CNT_W, miss_cnt  output  CNT_W, cnt_clr  input  1 SHALL form the counter readout and clear.

Function
REQ-011 The FSM SHALL have the states IDLE, SEARCH and DONE.
REQ-012 pc_ready SHALL be 1 only in IDLE; a query is accepted when pc_valid&&pc_ready, latching pc and tbl_count and moving to SEARCH.
REQ-013 SEARCH SHALL start with lo=0, hi=tbl_count-1, ans=none, and perform one probe per cycle at mid=lo+(hi-lo)/2.
- If tbl[mid] <= pc (unsigned): ans=mid, lo=mid+1.
- Otherwise: hi=mid-1.
- Exit to DONE when lo>hi, using signed-safe IDX_W+1-bit indices.
REQ-014 When tbl_count==0, SEARCH SHALL be skipped and the FSM SHALL go straight to DONE with a miss.
REQ-015 Search length SHALL be at most $clog2(DEPTH)+1 probe cycles; res_valid asserts the cycle after the last probe.
REQ-016 In DONE the block SHALL drive res_valid=1.
- On a hit: res_hit=1, res_idx=ans, res_base=tbl[ans].
- On a miss (no entry <= pc): res_hit=0, res_idx=0, res_base=0.
- Outputs are held stable until res_ready.
REQ-017 On res_valid&&res_ready the FSM SHALL return to IDLE, so pc_ready is 1 in the next cycle.
REQ-018 On a result handshake, cnt[res_idx] (hit) or miss_cnt (miss) SHALL increment by 1, saturating at all-ones.
REQ-019 cnt_rdata SHALL equal cnt[cnt_raddr] registered, one cycle read latency.
REQ-020 cnt_clr SHALL zero all counters in the next cycle; it takes priority over a same-cycle increment.
REQ-021 Table writes SHALL take effect only in IDLE; tbl_we in SEARCH or DONE is ignored.
REQ-022 A table write and a query accept in the same IDLE cycle SHALL both proceed, with the search seeing the written value.
REQ-023 Table order is the caller's responsibility; an unsorted table yields an unspecified res_idx but no lock-up.

Reset
REQ-024 Asserting reset SHALL force IDLE and set pc_ready=1, res_valid=0, res_hit=0, res_idx=0, res_base=0, cnt_rdata=0, all counters=0, miss_cnt=0.
REQ-025 Reset mid-search or in DONE SHALL abandon the query with no counter update.
REQ-026 Table contents SHALL NOT be reset.

Structure
REQ-027 Package function_profiler_pkg SHALL hold the state enum and the default parameter constants.
REQ-028 The table storage SHALL be one sub-module, profiler_table: 1 write port plus 1 asynchronous read port at mid.

Verification
REQ-029 Load tbl={0x100,0x200,0x300,0x400}, tbl_count=4, pc=0x250 -> res_hit=1, idx=1, base=0x200, cnt[1]=1.
REQ-030 Same table, pc=0x400 -> idx=3, base=0x400; pc=0x0FF -> res_hit=0, miss_cnt=1.
REQ-031 tbl_count=0, pc=0x500 -> miss within 2 cycles of accept.
REQ-032 Hold res_ready=0 for 5 cycles -> res_valid and result stable, pc_ready=0, tbl_we ignored.
REQ-033 CNT_W=2 with 5 hits on idx 2 -> cnt[2]=3; cnt_clr during a hit handshake -> cnt[2]=0.
REQ-034 Assert reset during SEARCH -> IDLE next edge, counters 0; DEPTH=256 full table with random pcs -> results match a reference model, at most 9 probe cycles each.
